// File: rtl/activation_packer_16x16b.sv
// Activation packer: gathers signed DATA_W elements into a LANES-wide word
// for a downstream adder stage. One assembly register plus one output
// register; a partial word is closed early by s_last and zero-padded.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   s_valid/s_ready   element handshake; s_data element, s_last closes word
//   m_valid/m_ready   packed word handshake
//   m_data            lane i at [(i+1)*DATA_W-1 : i*DATA_W]
//   m_last            word was closed by s_last
//   m_count           number of valid lanes (1..LANES)
module activation_packer_16x16b #(
  parameter int DATA_W = 16,
  parameter int LANES  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_W-1:0]       s_data,
  input  logic                    s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_W*LANES-1:0] m_data,
  output logic                    m_last,
  output logic [4:0]              m_count
);

  localparam int PW = DATA_W * LANES;
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic {
    COLLECTING = 1'b0,
    HELD       = 1'b1
  } asm_state_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  asm_state_t       asm_state_q, asm_state_d;
  out_state_t       out_state_q, out_state_d;
  logic [LW-1:0]    lane_q, lane_d;
  logic [PW-1:0]    asm_q, asm_d;
  logic             hold_last_q, hold_last_d;
  logic [4:0]       hold_count_q, hold_count_d;
  logic [PW-1:0]    out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic [4:0]       out_count_q, out_count_d;

  logic             in_fire;
  logic             out_fire;
  logic             out_free;
  logic             last_lane;
  logic             close;
  logic [PW-1:0]    word_w;
  logic [4:0]       count_w;

  // s_ready is a function of registered state and reset only
  assign s_ready = ~reset & (asm_state_q == COLLECTING);

  assign m_valid = (out_state_q == FULL);
  assign m_data  = out_data_q;
  assign m_last  = out_last_q;
  assign m_count = out_count_q;

  assign in_fire   = s_valid & s_ready;
  assign out_fire  = m_valid & m_ready;
  assign out_free  = (out_state_q == EMPTY) | out_fire;
  assign last_lane = (lane_q == LW'(LANES - 1));
  assign close     = in_fire & (last_lane | s_last);
  assign count_w   = 5'(lane_q) + 5'd1;

  // Assembly contents with the incoming element merged in. Lanes above
  // the current one are still zero because the register is cleared on
  // every close, which gives the zero padding for partial words.
  always_comb begin
    word_w = asm_q;
    word_w[int'(lane_q)*DATA_W +: DATA_W] = s_data;
  end

  always_comb begin
    asm_state_d  = asm_state_q;
    out_state_d  = out_state_q;
    lane_d       = lane_q;
    asm_d        = asm_q;
    hold_last_d  = hold_last_q;
    hold_count_d = hold_count_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    out_count_d  = out_count_q;

    if (out_fire) begin
      out_state_d = EMPTY;
    end

    unique case (asm_state_q)
      COLLECTING: begin
        if (close) begin
          lane_d = '0;
          if (out_free) begin
            out_data_d  = word_w;
            out_last_d  = s_last;
            out_count_d = count_w;
            out_state_d = FULL;
            asm_d       = '0;
          end else begin
            asm_d        = word_w;
            hold_last_d  = s_last;
            hold_count_d = count_w;
            asm_state_d  = HELD;
          end
        end else if (in_fire) begin
          asm_d  = word_w;
          lane_d = lane_q + LW'(1);
        end
      end
      HELD: begin
        // held word replaces the one leaving the output register
        if (out_fire) begin
          out_data_d  = asm_q;
          out_last_d  = hold_last_q;
          out_count_d = hold_count_q;
          out_state_d = FULL;
          asm_d       = '0;
          asm_state_d = COLLECTING;
        end
      end
      default: begin
        asm_state_d = COLLECTING;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      asm_state_q  <= COLLECTING;
      out_state_q  <= EMPTY;
      lane_q       <= '0;
      asm_q        <= '0;
      hold_last_q  <= 1'b0;
      hold_count_q <= '0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      out_count_q  <= '0;
    end else begin
      asm_state_q  <= asm_state_d;
      out_state_q  <= out_state_d;
      lane_q       <= lane_d;
      asm_q        <= asm_d;
      hold_last_q  <= hold_last_d;
      hold_count_q <= hold_count_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      out_count_q  <= out_count_d;
    end
  end

endmodule
